// File: rtl/rs232_avs_responder.sv
// Avalon-MM RS232 responder: 8N1 UART RX/TX behind RX (0x0), TX (0x4) and STATUS (0x8) registers.
// Build option RS232_RX_FIFO_EN selects a 4-entry RX FIFO instead of a single holding register.
module rs232_avs_responder #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        avm_clk,
   input  logic        avm_rst,
   input  logic [4:0]  avs_address,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic        avs_waitrequest,
   input  logic        uart_rxd,
   output logic        uart_txd
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   rx_state_t       r_rx_state, w_rx_next;
   tx_state_t       r_tx_state, w_tx_next;

   logic            r_rxd_meta, r_rxd_sync;
   logic [CW-1:0]   r_rx_cnt;
   logic [2:0]      r_rx_bit;
   logic [7:0]      r_rx_shift;
   logic            w_rx_tick, w_rx_half, w_rx_cnt_clr, w_rx_shift_en, w_rx_done, w_rx_ferr;

   logic [CW-1:0]   r_tx_cnt;
   logic [2:0]      r_tx_bit;
   logic [7:0]      r_tx_shift;
   logic            w_tx_tick, w_tx_cnt_clr, w_tx_shift_en, w_tx_ready, w_txd;

   logic            r_ack, r_pop_pend, r_clr_ov, r_clr_fe, r_overrun, r_frame_err;
   logic [31:0]     r_readdata, w_rd_mux, w_status;
   logic            w_req, w_acc_a, w_acc_b, w_sel_rx, w_sel_tx, w_sel_st;
   logic            w_pop, w_push, w_ovr_set, w_tx_load;
   logic            w_rx_full, w_rx_valid;
   logic [7:0]      w_rx_data;
   logic            w_unused;

   assign w_unused = ^avs_writedata[31:8];

   // Handshake: a request (read or write held high) stalls one cycle while ack is low
   // (cycle A, readdata registered), then completes with waitrequest low (cycle B);
   // side effects commit at the end of cycle B.
   assign w_req           = avs_read | avs_write;
   assign w_acc_a         = w_req & ~r_ack;
   assign w_acc_b         = w_req & r_ack;
   assign avs_waitrequest = w_acc_a;
   assign avs_readdata    = r_readdata;

   assign w_sel_rx = (avs_address == 5'd0);
   assign w_sel_tx = (avs_address == 5'd4);
   assign w_sel_st = (avs_address == 5'd8);

   assign w_status = {22'd0, r_frame_err, r_overrun, w_rx_valid, w_tx_ready, 6'd0};

   always_comb begin
      w_rd_mux = '0;
      if (w_sel_rx)
         w_rd_mux = {24'd0, w_rx_valid ? w_rx_data : 8'd0};
      else if (w_sel_st)
         w_rd_mux = w_status;
   end

   // Pop/clear decisions are latched in cycle A so only what was reported gets consumed.
   always_ff @(posedge avm_clk) begin
      if (avm_rst) begin
         r_ack      <= 1'b0;
         r_readdata <= '0;
         r_pop_pend <= 1'b0;
         r_clr_ov   <= 1'b0;
         r_clr_fe   <= 1'b0;
      end else begin
         r_ack <= w_acc_a;
         if (w_acc_a) begin
            r_pop_pend <= avs_read & w_sel_rx & w_rx_valid;
            r_clr_ov   <= avs_read & w_sel_st & r_overrun;
            r_clr_fe   <= avs_read & w_sel_st & r_frame_err;
            if (avs_read)
               r_readdata <= w_rd_mux;
         end
      end
   end

   assign w_pop     = w_acc_b & avs_read & r_pop_pend;
   assign w_tx_load = w_acc_b & avs_write & ~avs_read & w_sel_tx & w_tx_ready;
   assign w_push    = w_rx_done & (~w_rx_full | w_pop);
   assign w_ovr_set = w_rx_done & w_rx_full & ~w_pop;

   always_ff @(posedge avm_clk) begin
      if (avm_rst) begin
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_overrun   <= w_ovr_set | (r_overrun & ~(w_acc_b & r_clr_ov));
         r_frame_err <= w_rx_ferr | (r_frame_err & ~(w_acc_b & r_clr_fe));
      end
   end

   // ---------------- RX buffer ----------------
`ifdef RS232_RX_FIFO_EN
   logic [7:0] r_fifo [4];
   logic [1:0] r_wr_ptr, r_rd_ptr;
   logic [2:0] r_count;

   assign w_rx_full  = (r_count == 3'd4);
   assign w_rx_valid = (r_count != 3'd0);
   assign w_rx_data  = r_fifo[r_rd_ptr];

   always_ff @(posedge avm_clk) begin
      if (w_push)
         r_fifo[r_wr_ptr] <= r_rx_shift;
   end

   always_ff @(posedge avm_clk) begin
      if (avm_rst) begin
         r_wr_ptr <= 2'd0;
         r_rd_ptr <= 2'd0;
         r_count  <= 3'd0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 2'd1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 2'd1;
         r_count <= r_count + {2'd0, w_push} - {2'd0, w_pop};
      end
   end
`else
   logic [7:0] r_hold;
   logic       r_hold_vld;

   assign w_rx_full  = r_hold_vld;
   assign w_rx_valid = r_hold_vld;
   assign w_rx_data  = r_hold;

   always_ff @(posedge avm_clk) begin
      if (avm_rst) begin
         r_hold     <= 8'd0;
         r_hold_vld <= 1'b0;
      end else if (w_push) begin
         r_hold     <= r_rx_shift;
         r_hold_vld <= 1'b1;
      end else if (w_pop) begin
         r_hold_vld <= 1'b0;
      end
   end
`endif

   // ---------------- RX path ----------------
   always_ff @(posedge avm_clk) begin
      if (avm_rst) begin
         r_rxd_meta <= 1'b1;
         r_rxd_sync <= 1'b1;
      end else begin
         r_rxd_meta <= uart_rxd;
         r_rxd_sync <= r_rxd_meta;
      end
   end

   assign w_rx_tick = (r_rx_cnt == BIT_LAST);
   assign w_rx_half = (r_rx_cnt == HALF_LAST);

   always_ff @(posedge avm_clk) begin
      if (avm_rst)
         r_rx_state <= RX_IDLE;
      else
         r_rx_state <= w_rx_next;
   end

   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         RX_IDLE:  if (!r_rxd_sync) w_rx_next = RX_START;
         RX_START: if (w_rx_half) w_rx_next = r_rxd_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
         RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
         default:  w_rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      w_rx_cnt_clr  = 1'b0;
      w_rx_shift_en = 1'b0;
      w_rx_done     = 1'b0;
      w_rx_ferr     = 1'b0;
      case (r_rx_state)
         RX_IDLE:  w_rx_cnt_clr = 1'b1;
         RX_START: w_rx_cnt_clr = w_rx_half;
         RX_DATA: begin
            w_rx_cnt_clr  = w_rx_tick;
            w_rx_shift_en = w_rx_tick;
         end
         RX_STOP: begin
            w_rx_cnt_clr = w_rx_tick;
            w_rx_done    = w_rx_tick & r_rxd_sync;
            w_rx_ferr    = w_rx_tick & ~r_rxd_sync;
         end
         default:  w_rx_cnt_clr = 1'b1;
      endcase
   end

   always_ff @(posedge avm_clk) begin
      if (avm_rst) begin
         r_rx_cnt   <= '0;
         r_rx_bit   <= 3'd0;
         r_rx_shift <= 8'd0;
      end else begin
         r_rx_cnt <= w_rx_cnt_clr ? '0 : r_rx_cnt + 1'b1;
         if (w_rx_shift_en) begin
            r_rx_shift <= {r_rxd_sync, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
         end else if (r_rx_state != RX_DATA) begin
            r_rx_bit <= 3'd0;
         end
      end
   end

   // ---------------- TX path ----------------
   assign w_tx_tick  = (r_tx_cnt == BIT_LAST);
   assign w_tx_ready = (r_tx_state == TX_IDLE);
   assign uart_txd   = w_txd;

   always_ff @(posedge avm_clk) begin
      if (avm_rst)
         r_tx_state <= TX_IDLE;
      else
         r_tx_state <= w_tx_next;
   end

   always_comb begin
      w_tx_next = r_tx_state;
      case (r_tx_state)
         TX_IDLE:  if (w_tx_load) w_tx_next = TX_START;
         TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
         TX_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
         TX_STOP:  if (w_tx_tick) w_tx_next = TX_IDLE;
         default:  w_tx_next = TX_IDLE;
      endcase
   end

   always_comb begin
      w_tx_cnt_clr  = 1'b0;
      w_tx_shift_en = 1'b0;
      w_txd         = 1'b1;
      case (r_tx_state)
         TX_IDLE:  w_tx_cnt_clr = 1'b1;
         TX_START: begin
            w_tx_cnt_clr = w_tx_tick;
            w_txd        = 1'b0;
         end
         TX_DATA: begin
            w_tx_cnt_clr  = w_tx_tick;
            w_tx_shift_en = w_tx_tick;
            w_txd         = r_tx_shift[0];
         end
         TX_STOP:  w_tx_cnt_clr = w_tx_tick;
         default:  w_tx_cnt_clr = 1'b1;
      endcase
   end

   always_ff @(posedge avm_clk) begin
      if (avm_rst) begin
         r_tx_cnt   <= '0;
         r_tx_bit   <= 3'd0;
         r_tx_shift <= 8'd0;
      end else begin
         r_tx_cnt <= w_tx_cnt_clr ? '0 : r_tx_cnt + 1'b1;
         if (w_tx_load)
            r_tx_shift <= avs_writedata[7:0];
         else if (w_tx_shift_en)
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
         if (w_tx_shift_en)
            r_tx_bit <= r_tx_bit + 3'd1;
         else if (r_tx_state != TX_DATA)
            r_tx_bit <= 3'd0;
      end
   end

endmodule

// File: tb/tb_rs232_avs_responder.sv
// Bench for rs232_avs_responder: scoreboarded bus reads and TX frames against a queue-based model.
module tb_rs232_avs_responder;
   localparam int CPB = 8;
`ifdef RS232_RX_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif

   logic        avm_clk = 1'b0;
   logic        avm_rst = 1'b1;
   logic [4:0]  avs_address = 5'd0;
   logic        avs_read = 1'b0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = 32'd0;
   logic [31:0] avs_readdata;
   logic        avs_waitrequest;
   logic        uart_rxd = 1'b1;
   logic        uart_txd;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   logic [7:0]  tx_exp_q[$];
   logic [7:0]  m_rx_q[$];
   logic        m_ov = 1'b0;
   logic        m_fe = 1'b0;
   bit          tx_mon_en = 1'b1;

   always #5 avm_clk = ~avm_clk;

   rs232_avs_responder #(.CLKS_PER_BIT(CPB)) dut (
      .avm_clk(avm_clk),
      .avm_rst(avm_rst),
      .avs_address(avs_address),
      .avs_read(avs_read),
      .avs_readdata(avs_readdata),
      .avs_write(avs_write),
      .avs_writedata(avs_writedata),
      .avs_waitrequest(avs_waitrequest),
      .uart_rxd(uart_rxd),
      .uart_txd(uart_txd)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_status(input logic tx_rdy);
      return {22'd0, m_fe, m_ov, (m_rx_q.size() != 0), tx_rdy, 6'd0};
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge avm_clk);
      #1;
   endtask

   task automatic bus_access(input logic rd, input logic wr, input logic [4:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rd);
      int n;
      if (rd) exp_q.push_back(exp_rd);
      @(posedge avm_clk);
      #1;
      avs_read = rd;
      avs_write = wr;
      avs_address = addr;
      avs_writedata = wdata;
      @(negedge avm_clk);
      check("waitreq_cycle_a", {31'd0, avs_waitrequest}, 32'd1);
      n = 0;
      do begin
         @(negedge avm_clk);
         n++;
      end while (avs_waitrequest && n < 8);
      check("access_wait_cycles", n, 1);
      @(posedge avm_clk);
      #1;
      avs_read = 1'b0;
      avs_write = 1'b0;
   endtask

   task automatic read_status(input logic tx_rdy);
      bus_access(1'b1, 1'b0, 5'd8, 32'd0, model_status(tx_rdy));
      m_ov = 1'b0;
      m_fe = 1'b0;
   endtask

   task automatic read_rx();
      logic [31:0] e;
      e = (m_rx_q.size() != 0) ? {24'd0, m_rx_q.pop_front()} : 32'd0;
      bus_access(1'b1, 1'b0, 5'd0, 32'd0, e);
   endtask

   task automatic write_tx(input logic [7:0] b, input logic expect_frame);
      logic [31:0] w;
      w = $urandom;
      w[7:0] = b;
      if (expect_frame) tx_exp_q.push_back(b);
      bus_access(1'b0, 1'b1, 5'd4, w, 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      uart_rxd = 1'b0;
      wait_cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         wait_cyc(CPB);
      end
      uart_rxd = stop_ok;
      wait_cyc(CPB);
      uart_rxd = 1'b1;
      wait_cyc(CPB + 4);
      if (!stop_ok) m_fe = 1'b1;
      else if (m_rx_q.size() < DEPTH) m_rx_q.push_back(b);
      else m_ov = 1'b1;
   endtask

   // Read scoreboard: every completed read is matched against the oldest expectation.
   always @(negedge avm_clk) begin
      if (avs_read && !avs_waitrequest) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL read_unexpected actual=0x%08h expected=none", avs_readdata);
         end else begin
            check("readdata", avs_readdata, exp_q.pop_front());
         end
      end
   end

   // TX monitor: decodes frames on uart_txd at mid-bit and matches queued bytes.
   initial begin
      logic       prev;
      logic [7:0] b;
      prev = 1'b1;
      forever begin
         @(negedge avm_clk);
         if (tx_mon_en && prev && !uart_txd) begin
            repeat (CPB / 2) @(negedge avm_clk);
            check("tx_start_bit", {31'd0, uart_txd}, 32'd0);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge avm_clk);
               b[i] = uart_txd;
            end
            repeat (CPB) @(negedge avm_clk);
            check("tx_stop_bit", {31'd0, uart_txd}, 32'd1);
            if (tx_exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL tx_unexpected_frame actual=0x%02h expected=none", b);
            end else begin
               check("tx_byte", {24'd0, b}, {24'd0, tx_exp_q.pop_front()});
            end
         end
         prev = uart_txd;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [9:0]  frame;
      logic [7:0]  rb;
      logic [4:0]  ra;
      int          op;

      // Reset values
      repeat (3) @(posedge avm_clk);
      @(negedge avm_clk);
      check("rst_readdata", avs_readdata, 32'd0);
      check("rst_waitreq", {31'd0, avs_waitrequest}, 32'd0);
      check("rst_txd", {31'd0, uart_txd}, 32'd1);
      @(posedge avm_clk);
      #1;
      avm_rst = 1'b0;
      read_status(1'b1);

      // RX of 0xA5
      send_byte(8'hA5, 1'b1);
      read_status(1'b1);
      read_rx();
      read_status(1'b1);

      // TX waveform of 0x3C, then tx_ready boundary around 80 cycles
      frame = {1'b1, 8'h3C, 1'b0};
      write_tx(8'h3C, 1'b1);
      for (int k = 0; k < 10 * CPB - 1; k++) begin
         @(negedge avm_clk);
         check("tx_wave", {31'd0, uart_txd}, {31'd0, frame[k / CPB]});
      end
      read_status(1'b0);
      read_status(1'b1);

      // Second write mid-frame is dropped
      write_tx(8'h96, 1'b1);
      wait_cyc(20);
      read_status(1'b0);
      write_tx(8'hFF, 1'b0);
      wait_cyc(10 * CPB);
      read_status(1'b1);

      // Read+write together acts as a read; TX read and unmapped accesses return 0
      bus_access(1'b1, 1'b1, 5'd4, 32'h55, 32'd0);
      bus_access(1'b1, 1'b0, 5'd12, 32'd0, 32'd0);
      bus_access(1'b0, 1'b1, 5'd20, 32'h1234_5678, 32'd0);
      wait_cyc(2);
      read_status(1'b1);

      // Frame error then glitch rejection
      send_byte(8'h11, 1'b0);
      read_status(1'b1);
      read_status(1'b1);
      uart_rxd = 1'b0;
      wait_cyc(3);
      uart_rxd = 1'b1;
      wait_cyc(2 * CPB);
      read_status(1'b1);
      read_rx();

      // Five bytes without popping
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
      read_status(1'b1);
      for (int i = 0; i <= DEPTH; i++) read_rx();
      read_status(1'b1);

      // Randomized mix of operations
      for (int it = 0; it < 30; it++) begin
         op = $urandom_range(0, 5);
         case (op)
            0: send_byte(8'($urandom), ($urandom_range(0, 4) != 0));
            1: read_rx();
            2: read_status(1'b1);
            3: begin
               write_tx(8'($urandom), 1'b1);
               wait_cyc($urandom_range(5, 40));
               read_status(1'b0);
               if ($urandom_range(0, 1) == 1) write_tx(8'($urandom), 1'b0);
               wait_cyc(10 * CPB);
            end
            4: begin
               ra = 5'($urandom_range(1, 31));
               if (ra == 5'd4 || ra == 5'd8) ra = ra + 5'd1;
               bus_access(1'b1, 1'b0, ra, 32'd0, 32'd0);
            end
            default: begin
               ra = 5'($urandom_range(0, 31));
               if (ra == 5'd4) ra = 5'd5;
               bus_access(1'b0, 1'b1, ra, $urandom, 32'd0);
            end
         endcase
      end
      read_status(1'b1);

      // Reset mid RX frame and mid TX frame with a byte waiting
      rb = 8'($urandom);
      send_byte(rb, 1'b1);
      tx_mon_en = 1'b0;
      write_tx(8'hA5, 1'b0);
      uart_rxd = 1'b0;
      wait_cyc(3 * CPB);
      avm_rst = 1'b1;
      uart_rxd = 1'b1;
      @(posedge avm_clk);
      #1;
      avm_rst = 1'b0;
      m_rx_q.delete();
      m_ov = 1'b0;
      m_fe = 1'b0;
      @(negedge avm_clk);
      check("rst_mid_frame_txd", {31'd0, uart_txd}, 32'd1);
      wait_cyc(2 * CPB);
      tx_mon_en = 1'b1;
      read_status(1'b1);
      read_rx();
      send_byte(8'h5A, 1'b1);
      read_rx();
      read_status(1'b1);

      wait_cyc(4);
      check("read_queue_drained", exp_q.size(), 0);
      check("tx_queue_drained", tx_exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
